// File: rtl/seg_scan_if.sv
// seg_scan_if: scanned seven-segment input bus plus the decoded-frame valid/ready output.
interface seg_scan_if;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] out_bcd;
    logic        out_sign;
    logic        out_err;
    logic        overrun;
    modport master (output seg, dig_en, out_ready, input out_valid, out_bcd, out_sign, out_err, overrun);
    modport slave (input seg, dig_en, out_ready, output out_valid, out_bcd, out_sign, out_err, overrun);
endinterface

// File: rtl/seg_scan_to_bcd.sv
// seg_scan_to_bcd: debounces a multiplexed 4-position seven-segment scan and rebuilds
// signed 3-digit BCD frames, delivered over a valid/ready handshake.
module seg_scan_to_bcd #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int IW = $clog2(TIMEOUT);
    localparam logic [7:0]    CMAX = 8'(SETTLE - 1);
    localparam logic [IW-1:0] IMAX = IW'(TIMEOUT - 1);

    logic [6:0]    r_seg;
    logic [3:0]    r_en;
    logic [10:0]   r_prev;
    logic [7:0]    r_cnt;
    logic          r_dwell;
    logic [3:0]    r_mask;
    logic [3:0]    r_err;
    logic [11:0]   r_slot;
    logic          r_sign;
    logic [IW-1:0] r_idle;
    logic          r_valid;
    logic [11:0]   r_bcd;
    logic          r_osign;
    logic          r_oerr;
    logic          r_ovr;

    logic       w_chg, w_cap, w_done, w_free, w_tmo, w_bad, w_neg, w_sbad;
    logic [3:0] w_val;

    // A change seen this cycle also blocks capture, so a saturated counter left over
    // from a stable non-one-hot strobe can never capture a fresh, unsettled value.
    always_comb begin
        w_chg  = {r_en, r_seg} != r_prev;
        w_cap  = r_cnt == CMAX && !w_chg && $onehot(r_en) && !r_dwell;
        w_done = r_mask == 4'hF;
        w_free = !r_valid || bus.out_ready;
        w_tmo  = r_idle == IMAX && !w_cap;
        w_neg  = r_seg == 7'b0000001;
        w_sbad = r_seg != 7'b0000000 && !w_neg;
        {w_bad, w_val} = 5'h1F;
        case (r_seg)
            7'b1111110, 7'b0000000: {w_bad, w_val} = 5'd0;
            7'b0110000: {w_bad, w_val} = 5'd1;
            7'b1101101: {w_bad, w_val} = 5'd2;
            7'b1111001: {w_bad, w_val} = 5'd3;
            7'b0110011: {w_bad, w_val} = 5'd4;
            7'b1011011: {w_bad, w_val} = 5'd5;
            7'b1011111: {w_bad, w_val} = 5'd6;
            7'b1110000: {w_bad, w_val} = 5'd7;
            7'b1111111: {w_bad, w_val} = 5'd8;
            7'b1111011: {w_bad, w_val} = 5'd9;
            default: {w_bad, w_val} = 5'h1F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= '0;
            r_en    <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
            r_dwell <= 1'b0;
            r_mask  <= '0;
            r_err   <= '0;
            r_slot  <= '0;
            r_sign  <= 1'b0;
            r_idle  <= '0;
            r_valid <= 1'b0;
            r_bcd   <= '0;
            r_osign <= 1'b0;
            r_oerr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_seg   <= bus.seg;
            r_en    <= bus.dig_en;
            r_prev  <= {r_en, r_seg};
            r_cnt   <= w_chg ? '0 : r_cnt == CMAX ? r_cnt : r_cnt + 8'd1;
            r_dwell <= w_chg ? 1'b0 : r_dwell | w_cap;
            r_idle  <= w_cap || w_tmo ? '0 : r_idle + IW'(1);
            r_mask  <= w_tmo ? '0 : (w_done ? 4'h0 : r_mask) | (w_cap ? r_en : 4'h0);
            if (w_cap) begin
                if (r_en[3]) {r_sign, r_err[3]} <= {w_neg, w_sbad};
                if (r_en[2]) {r_slot[11:8], r_err[2]} <= {w_val, w_bad};
                if (r_en[1]) {r_slot[7:4], r_err[1]} <= {w_val, w_bad};
                if (r_en[0]) {r_slot[3:0], r_err[0]} <= {w_val, w_bad};
            end else if (w_tmo) begin
                r_err <= '0;
            end
            r_ovr <= w_done && !w_free;
            if (w_done && w_free) begin
                r_valid <= 1'b1;
                r_bcd   <= r_slot;
                r_osign <= r_sign;
                r_oerr  <= |r_err;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_bcd   = r_bcd;
    assign bus.out_sign  = r_sign_out();
    assign bus.out_err   = r_oerr;
    assign bus.overrun   = r_ovr;

    function automatic logic r_sign_out();
        return r_osign;
    endfunction
endmodule

// File: tb/tb_seg_scan_to_bcd.sv
// tb_seg_scan_to_bcd: directed and randomized scans checked against a table-driven
// frame model; frames are recorded at the handshake and compared per scenario.
`timescale 1ns/1ps
module tb_seg_scan_to_bcd;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_ovr = 0;
    logic [13:0] got_q[$];
    int got_t[$];
    logic [6:0] pat[10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    seg_scan_if bus();
    seg_scan_to_bcd #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // every handshake is recorded as {sign, err, bcd} with its cycle number
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back({bus.out_sign, bus.out_err, bus.out_bcd});
            got_t.push_back(cyc);
        end
        if (bus.overrun) n_ovr++;
    end

    function automatic logic [4:0] dec(input logic [6:0] s);
        dec = s == 7'd0 ? 5'h00 : 5'h1F;
        for (int i = 0; i < 10; i++) if (s == pat[i]) dec = {1'b0, 4'(i)};
    endfunction

    function automatic logic [13:0] model(input logic [6:0] sg, input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
        logic [4:0] dh, dt, du;
        logic bad;
        dh = dec(h);
        dt = dec(t);
        du = dec(u);
        bad = dh[4] | dt[4] | du[4] | (sg != 7'd0 && sg != 7'd1);
        return {sg == 7'd1, bad, dh[3:0], dt[3:0], du[3:0]};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] en, input logic [6:0] s, input int n);
        bus.dig_en = en;
        bus.seg = s;
        tick(n);
    endtask

    task automatic frame(input logic [6:0] sg, input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
        drive(4'b1000, sg, 8);
        drive(4'b0100, h, 8);
        drive(4'b0010, t, 8);
        drive(4'b0001, u, 8);
        drive(4'b0000, 7'd0, 2);
    endtask

    task automatic wait_got(output logic [13:0] g, output bit ok);
        ok = 0;
        g = 14'h3FFF;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (got_q.size() != 0) ok = 1;
            else tick();
        end
        if (ok) begin
            g = got_q.pop_front();
            void'(got_t.pop_front());
        end
    endtask

    task automatic test_reset;
        bus.seg = '0;
        bus.dig_en = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        tick(3);
        n_vec++;
        if ({bus.out_valid, bus.out_bcd, bus.out_sign, bus.out_err, bus.overrun} !== 16'h0) begin
            n_err++;
            $display("FAIL reset outputs got %h want 0", {bus.out_valid, bus.out_bcd, bus.out_sign, bus.out_err, bus.overrun});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic;
        int t0;
        got_q.delete();
        got_t.delete();
        drive(4'b1000, 7'b0000001, 8);
        drive(4'b0100, 7'b0110000, 8);
        drive(4'b0010, 7'b1101101, 8);
        t0 = cyc;
        drive(4'b0001, 7'b1111001, 8);
        drive(4'b0000, 7'd0, 4);
        n_vec++;
        if (got_q.size() != 1) begin
            n_err++;
            $display("FAIL basic pulse count got %0d want 1", got_q.size());
        end else begin
            n_vec++;
            if (got_q[0] !== {1'b1, 1'b0, 12'h123}) begin
                n_err++;
                $display("FAIL basic frame got %h want %h", got_q[0], {1'b1, 1'b0, 12'h123});
            end
            n_vec++;
            if (got_t[0] < t0 + SETTLE + 2 || got_t[0] > t0 + SETTLE + 3) begin
                n_err++;
                $display("FAIL basic latency got cycle %0d want %0d..%0d", got_t[0], t0 + SETTLE + 2, t0 + SETTLE + 3);
            end
        end
    endtask

    task automatic test_glitch;
        logic [13:0] g;
        bit ok;
        got_q.delete();
        drive(4'b1000, 7'b0000000, 8);
        drive(4'b0100, 7'b0110000, 8);
        drive(4'b0010, 7'b1101101, SETTLE - 1);
        drive(4'b0001, 7'b1111110, 8);
        drive(4'b0000, 7'd0, 6);
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++;
            $display("FAIL glitch_short frames got %0d want 0", got_q.size());
        end
        drive(4'b0010, 7'b1101101, 2);
        drive(4'b0010, 7'b1111001, 8);
        drive(4'b0000, 7'd0, 2);
        wait_got(g, ok);
        n_vec++;
        if (!ok || g !== {1'b0, 1'b0, 12'h130}) begin
            n_err++;
            $display("FAIL glitch_frame got %h ok=%0d want %h", g, ok, {1'b0, 1'b0, 12'h130});
        end
    endtask

    task automatic test_error;
        logic [13:0] g;
        bit ok;
        got_q.delete();
        frame(7'b0000000, 7'b1111111, 7'b0000000, 7'b0010000);
        wait_got(g, ok);
        n_vec++;
        if (!ok || g !== {1'b0, 1'b1, 12'h80F}) begin
            n_err++;
            $display("FAIL error_frame got %h ok=%0d want %h", g, ok, {1'b0, 1'b1, 12'h80F});
        end
    endtask

    task automatic test_overrun;
        logic [13:0] g;
        bit ok;
        got_q.delete();
        n_ovr = 0;
        bus.out_ready = 1'b0;
        frame(7'b0000001, 7'b0110011, 7'b1011011, 7'b1011111);
        n_vec++;
        if ({bus.out_valid, bus.out_sign, bus.out_err, bus.out_bcd} !== {1'b1, 1'b1, 1'b0, 12'h456}) begin
            n_err++;
            $display("FAIL overrun_held got %h want %h", {bus.out_valid, bus.out_sign, bus.out_err, bus.out_bcd}, {1'b1, 1'b1, 1'b0, 12'h456});
        end
        frame(7'b0000000, 7'b1110000, 7'b1111111, 7'b1111011);
        n_vec++;
        if (n_ovr != 1) begin
            n_err++;
            $display("FAIL overrun_pulse cycles got %0d want 1", n_ovr);
        end
        n_vec++;
        if ({bus.out_valid, bus.out_sign, bus.out_err, bus.out_bcd} !== {1'b1, 1'b1, 1'b0, 12'h456}) begin
            n_err++;
            $display("FAIL overrun_unchanged got %h want %h", {bus.out_valid, bus.out_sign, bus.out_err, bus.out_bcd}, {1'b1, 1'b1, 1'b0, 12'h456});
        end
        bus.out_ready = 1'b1;
        tick(2);
        wait_got(g, ok);
        n_vec++;
        if (!ok || g !== {1'b1, 1'b0, 12'h456} || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_drain got %h valid=%b want %h valid=0", g, bus.out_valid, {1'b1, 1'b0, 12'h456});
        end
        frame(7'b0000000, 7'b1111110, 7'b1111110, 7'b0110000);
        wait_got(g, ok);
        n_vec++;
        if (!ok || g !== {1'b0, 1'b0, 12'h001}) begin
            n_err++;
            $display("FAIL overrun_next got %h ok=%0d want %h", g, ok, {1'b0, 1'b0, 12'h001});
        end
    endtask

    task automatic test_back_to_back;
        got_q.delete();
        n_ovr = 0;
        bus.out_ready = 1'b0;
        frame(7'b0000001, 7'b1101101, 7'b0110000, 7'b1111110);
        drive(4'b1000, 7'b0000000, 8);
        drive(4'b0100, 7'b1111001, 8);
        drive(4'b0010, 7'b0110011, 8);
        drive(4'b0001, 7'b1011011, 6);
        bus.out_ready = 1'b1;
        tick(2);
        drive(4'b0000, 7'd0, 4);
        n_vec++;
        if (got_q.size() != 2 || n_ovr != 0) begin
            n_err++;
            $display("FAIL b2b count got %0d frames %0d overruns want 2 and 0", got_q.size(), n_ovr);
        end else begin
            n_vec++;
            if (got_q[0] !== {1'b1, 1'b0, 12'h210} || got_q[1] !== {1'b0, 1'b0, 12'h345}) begin
                n_err++;
                $display("FAIL b2b data got %h %h want %h %h", got_q[0], got_q[1], {1'b1, 1'b0, 12'h210}, {1'b0, 1'b0, 12'h345});
            end
        end
    endtask

    task automatic test_timeout;
        logic [13:0] g;
        bit ok;
        got_q.delete();
        drive(4'b1000, 7'b0000001, 8);
        drive(4'b0100, 7'b1111111, 8);
        drive(4'b0000, 7'd0, TIMEOUT + 8);
        drive(4'b0010, 7'b0110000, 8);
        drive(4'b0001, 7'b0110000, 8);
        drive(4'b0000, 7'd0, 10);
        n_vec++;
        if (got_q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_partial got %0d frames valid=%b want 0", got_q.size(), bus.out_valid);
        end
        drive(4'b0000, 7'd0, TIMEOUT + 8);
        frame(7'b0000000, 7'b1011011, 7'b0110011, 7'b1111110);
        wait_got(g, ok);
        n_vec++;
        if (!ok || g !== {1'b0, 1'b0, 12'h540}) begin
            n_err++;
            $display("FAIL timeout_frame got %h ok=%0d want %h", g, ok, {1'b0, 1'b0, 12'h540});
        end
    endtask

    task automatic test_random;
        logic [6:0] p[4];
        logic [13:0] g, e;
        logic [4:0] d;
        bit ok;
        int ord[4];
        int r, k2, tmp;
        got_q.delete();
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 3; j++) begin
                r = $urandom_range(0, 11);
                if (r < 10) p[j] = pat[r];
                else if (r == 10) p[j] = 7'd0;
                else begin
                    do begin
                        p[j] = 7'($urandom);
                        d = dec(p[j]);
                    end while (!d[4]);
                end
            end
            r = $urandom_range(0, 5);
            p[3] = r < 2 ? 7'b0000001 : r < 4 ? 7'b0000000 : 7'($urandom);
            ord = '{0, 1, 2, 3};
            for (int j = 3; j > 0; j--) begin
                k2 = $urandom_range(0, j);
                tmp = ord[j];
                ord[j] = ord[k2];
                ord[k2] = tmp;
            end
            for (int j = 0; j < 4; j++) drive(4'(1 << ord[j]), p[ord[j]], $urandom_range(SETTLE + 1, SETTLE + 5));
            drive(4'b0000, 7'd0, 1);
            e = model(p[3], p[2], p[1], p[0]);
            wait_got(g, ok);
            n_vec++;
            if (!ok || g !== e) begin
                n_err++;
                $display("FAIL random[%0d] got %h ok=%0d want %h", k, g, ok, e);
            end
        end
        drive(4'b0000, 7'd0, 4);
    endtask

    task automatic test_reset_mid;
        got_q.delete();
        drive(4'b1000, 7'b0000001, 8);
        drive(4'b0100, 7'b0110000, 8);
        drive(4'b0010, 7'b1101101, 8);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_bcd, bus.out_sign, bus.out_err, bus.overrun} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid outputs got %h want 0", {bus.out_valid, bus.out_bcd, bus.out_sign, bus.out_err, bus.overrun});
        end
        tick();
        rst_n = 1'b1;
        drive(4'b0001, 7'b1111001, 8);
        drive(4'b0000, 7'd0, 10);
        n_vec++;
        if (got_q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid frame got %0d frames valid=%b want 0", got_q.size(), bus.out_valid);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_error();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
